// File: rtl/alu_operand_sequencer.sv
// Operand-entry front end for the board ALU: synchronizes and debounces the
// enter/clear push buttons, steps through A -> B -> function select, and
// captures the ALU result one cycle after the entry completes.
module alu_operand_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_enter_n,
    input  logic       key_clear_n,
    input  logic [2:0] sw_data,
    input  logic [1:0] sw_op,
    input  logic [3:0] alu_f,
    output logic [2:0] a_out,
    output logic [2:0] b_out,
    output logic [1:0] fun_select,
    output logic       operands_valid,
    output logic [3:0] f_hold,
    output logic [1:0] step
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StA    = 2'b00,
        StB    = 2'b01,
        StOp   = 2'b10,
        StShow = 2'b11
    } state_e;

    // Bit 0 is the enter key, bit 1 the clear key.
    logic [1:0]      raw;
    logic [1:0]      meta_q;
    logic [1:0]      sync_q;
    logic [1:0]      deb_q;
    logic [1:0]      deb_d;
    logic [1:0]      deb_prev_q;
    logic [CntW-1:0] cnt_q [2];
    logic [CntW-1:0] cnt_d [2];
    logic [1:0]      press;
    logic            enter_ev;
    logic            clear_ev;

    state_e     state_q, state_d;
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    logic [1:0] fun_q, fun_d;
    logic       valid_q, valid_d;
    logic [3:0] f_hold_q, f_hold_d;
    logic       capture_pend_q, capture_pend_d;

    assign raw = {key_clear_n, key_enter_n};

    // Two-flop synchronizers; released (1) out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    deb_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Debounced levels, their one-cycle-delayed copy, and the stability counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q      <= 2'b11;
            deb_prev_q <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Press event: one-cycle pulse on a debounced 1->0 edge; releases are ignored.
    assign press    = deb_prev_q & ~deb_q;
    assign enter_ev = press[0];
    assign clear_ev = press[1];

    // Next-state and register-load logic; clear overrides enter and any pending capture.
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        fun_d          = fun_q;
        valid_d        = valid_q;
        f_hold_d       = f_hold_q;
        capture_pend_d = 1'b0;

        if (capture_pend_q) begin
            f_hold_d = alu_f;
        end

        if (clear_ev) begin
            a_d      = '0;
            b_d      = '0;
            fun_d    = '0;
            valid_d  = 1'b0;
            f_hold_d = '0;
            state_d  = StA;
        end else if (enter_ev) begin
            unique case (state_q)
                StA: begin
                    a_d     = sw_data;
                    state_d = StB;
                end
                StB: begin
                    b_d     = sw_data;
                    state_d = StOp;
                end
                StOp: begin
                    fun_d          = sw_op;
                    valid_d        = 1'b1;
                    // Give the ALU one full cycle on the new operands before sampling.
                    capture_pend_d = 1'b1;
                    state_d        = StShow;
                end
                StShow: begin
                    valid_d = 1'b0;
                    state_d = StA;
                end
                default: state_d = StA;
            endcase
        end
    end

    // FSM state and ALU-facing registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StA;
            a_q            <= '0;
            b_q            <= '0;
            fun_q          <= '0;
            valid_q        <= 1'b0;
            f_hold_q       <= '0;
            capture_pend_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            fun_q          <= fun_d;
            valid_q        <= valid_d;
            f_hold_q       <= f_hold_d;
            capture_pend_q <= capture_pend_d;
        end
    end

    assign a_out          = a_q;
    assign b_out          = b_q;
    assign fun_select     = fun_q;
    assign operands_valid = valid_q;
    assign f_hold         = f_hold_q;
    assign step           = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: directed scenarios plus randomized
// key activity, compared against a transaction-level model of the entry sequence.
module tb_alu_operand_sequencer;

    localparam int unsigned DC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_enter_n;
    logic       key_clear_n;
    logic [2:0] sw_data;
    logic [1:0] sw_op;
    logic [3:0] alu_f;
    logic [2:0] a_out;
    logic [2:0] b_out;
    logic [1:0] fun_select;
    logic       operands_valid;
    logic [3:0] f_hold;
    logic [1:0] step;

    int checks = 0;
    int errors = 0;

    // Transaction-level model of the visible entry state.
    int m_step, m_a, m_b, m_op, m_valid, m_f;

    alu_operand_sequencer #(
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_enter_n   (key_enter_n),
        .key_clear_n   (key_clear_n),
        .sw_data       (sw_data),
        .sw_op         (sw_op),
        .alu_f         (alu_f),
        .a_out         (a_out),
        .b_out         (b_out),
        .fun_select    (fun_select),
        .operands_valid(operands_valid),
        .f_hold        (f_hold),
        .step          (step)
    );

    always #5 clk = ~clk;

    // The external ALU: 4-bit results, wrap mod 16.
    function automatic int alu_ref(input int a, input int b, input int op);
        case (op)
            0:       return (a + b) & 15;
            1:       return (a - b) & 15;
            2:       return (a ^ b) & 15;
            default: return (a << 1) & 15;
        endcase
    endfunction

    assign alu_f = 4'(alu_ref(int'(a_out), int'(b_out), int'(fun_select)));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".a"}, 32'(a_out), m_a);
        check({tag, ".b"}, 32'(b_out), m_b);
        check({tag, ".op"}, 32'(fun_select), m_op);
        check({tag, ".valid"}, 32'(operands_valid), m_valid);
        check({tag, ".f"}, 32'(f_hold), m_f);
        check({tag, ".step"}, 32'(step), m_step);
    endtask

    task automatic model_clear();
        m_step = 0; m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_f = 0;
    endtask

    task automatic model_enter();
        case (m_step)
            0: begin m_a = int'(sw_data); m_step = 1; end
            1: begin m_b = int'(sw_data); m_step = 2; end
            2: begin
                m_op = int'(sw_op);
                m_valid = 1;
                m_f = alu_ref(m_a, m_b, m_op);
                m_step = 3;
            end
            default: begin m_valid = 0; m_step = 0; end
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_keys(input bit en, input bit cl, input logic lvl);
        if (en) key_enter_n = lvl;
        if (cl) key_clear_n = lvl;
    endtask

    // Press (optionally with contact bounce on both edges), hold, release, settle.
    task automatic press(input bit en, input bit cl, input bit bounce, input int hold);
        if (bounce) begin
            for (int i = 0; i < 4; i++) begin
                drive_keys(en, cl, 1'b0);
                idle($urandom_range(1, 3));
                drive_keys(en, cl, 1'b1);
                idle($urandom_range(1, 2));
            end
        end
        drive_keys(en, cl, 1'b0);
        idle(hold);
        if (bounce) begin
            for (int i = 0; i < 3; i++) begin
                drive_keys(en, cl, 1'b1);
                idle($urandom_range(1, 2));
                drive_keys(en, cl, 1'b0);
                idle($urandom_range(1, 3));
            end
        end
        drive_keys(en, cl, 1'b1);
        idle(DC + 8);
        if (cl) model_clear();
        else if (en) model_enter();
    endtask

    // Low pulse shorter than the debounce window: must not register.
    task automatic glitch(input bit en, input bit cl);
        drive_keys(en, cl, 1'b0);
        idle($urandom_range(1, DC - 1));
        drive_keys(en, cl, 1'b1);
        idle(DC + 6);
    endtask

    initial begin
        int n;
        bit seen;

        rst_n = 1'b0;
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        sw_data = 3'd0;
        sw_op = 2'd0;
        model_clear();
        idle(3);
        rst_n = 1'b1;
        idle(2);
        check_all("reset");

        // Full entry with latency measurement on the first press.
        sw_data = 3'd3;
        key_enter_n = 1'b0;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (step != 2'd0) seen = 1;
        end
        check("enter_latency", 32'(seen && n >= int'(DC) + 2 && n <= int'(DC) + 4), 1);
        idle(4);
        key_enter_n = 1'b1;
        idle(DC + 8);
        model_enter();
        check_all("load_a");

        sw_data = 3'd2;
        press(1, 0, 0, 10);
        check_all("load_b");

        // Valid rises with fun_select; f_hold follows exactly one cycle later.
        sw_op = 2'd0;
        key_enter_n = 1'b0;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (operands_valid === 1'b1) seen = 1;
        end
        check("valid_rise_seen", 32'(seen), 1);
        check("valid_rise_fun", 32'(fun_select), 0);
        check("valid_rise_f_old", 32'(f_hold), 0);
        @(negedge clk);
        check("f_next_cycle", 32'(f_hold), 5);
        idle(4);
        key_enter_n = 1'b1;
        idle(DC + 8);
        model_enter();
        check_all("show_add");

        press(1, 0, 0, 9);
        check_all("fourth_enter");

        // Subtraction wrap.
        sw_data = 3'd2; press(1, 0, 0, 9);
        sw_data = 3'd5; press(1, 0, 0, 9);
        sw_op = 2'd1;   press(1, 0, 0, 9);
        check("wrap_f", 32'(f_hold), 13);
        check_all("wrap");
        press(1, 0, 0, 9);
        check("wrap_keep_f", 32'(f_hold), 13);
        check_all("wrap_exit");

        // Short glitch does nothing; bounce then long hold yields one event.
        key_enter_n = 1'b0;
        idle(3);
        key_enter_n = 1'b1;
        idle(DC + 6);
        check_all("glitch3");
        sw_data = 3'd6;
        press(1, 0, 1, 20);
        check_all("bounce");

        // Enter and clear together in S_OP: clear wins.
        sw_data = 3'd1; press(1, 0, 0, 9);
        check_all("to_op");
        press(1, 1, 0, 9);
        check_all("clear_priority");

        // Clear landing on the capture cycle suppresses the capture.
        sw_data = 3'd7; press(1, 0, 0, 9);
        sw_data = 3'd7; press(1, 0, 0, 9);
        sw_op = 2'd3;
        key_enter_n = 1'b0;
        idle(1);
        key_clear_n = 1'b0;
        idle(10);
        key_enter_n = 1'b1;
        key_clear_n = 1'b1;
        idle(DC + 8);
        model_enter();
        model_clear();
        check_all("clear_on_capture");

        // Asynchronous reset mid-entry.
        sw_data = 3'd4; press(1, 0, 0, 9);
        sw_data = 3'd3; press(1, 0, 0, 9);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all("async_reset");
        idle(2);
        rst_n = 1'b1;
        idle(2);
        sw_data = 3'd5;
        press(1, 0, 0, 9);
        check_all("after_reset_load_a");

        // Randomized activity.
        for (int it = 0; it < 40; it++) begin
            int act;
            act = int'($urandom_range(0, 9));
            sw_data = 3'($urandom);
            sw_op = 2'($urandom);
            case (act)
                0, 1, 2, 3, 4, 5: press(1, 0, 1'($urandom), int'($urandom_range(8, 14)));
                6: press(0, 1, 1'($urandom), int'($urandom_range(8, 14)));
                7: glitch(1'($urandom), 1'b1);
                8: press(1, 1, 0, 9);
                default: glitch(1, 0);
            endcase
            check_all($sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
